// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception bit positions, CP0 exccodes,
// the default exception vector and the exc_ctrl state encoding.
package cpu_defs;

    // Bit positions inside the one-hot exc_type sent to CP0
    localparam int EXC_INT  = 6;
    localparam int EXC_ADEL = 5;
    localparam int EXC_ADES = 4;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BP   = 2;
    localparam int EXC_RI   = 1;
    localparam int EXC_OV   = 0;

    // Bit positions inside the raw wb_exc flags from the commit stage
    localparam int WB_ADEL = 5;
    localparam int WB_ADES = 4;
    localparam int WB_SYS  = 3;
    localparam int WB_BP   = 2;
    localparam int WB_RI   = 1;
    localparam int WB_OV   = 0;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } exc_state_t;

    // Translate a one-hot exc_type into the CP0 exccode
    function automatic logic [4:0] exccode_of(input logic [6:0] exc_type);
        logic [4:0] code;
        code = EXCCODE_INT;
        if (exc_type[EXC_ADEL]) code = EXCCODE_ADEL;
        if (exc_type[EXC_ADES]) code = EXCCODE_ADES;
        if (exc_type[EXC_SYS])  code = EXCCODE_SYS;
        if (exc_type[EXC_BP])   code = EXCCODE_BP;
        if (exc_type[EXC_RI])   code = EXCCODE_RI;
        if (exc_type[EXC_OV])   code = EXCCODE_OV;
        return code;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority picker: int > adel > ri > ov > sys > bp > ades > eret.
// Produces a one-hot exc_type, or is_eret alone when only eret is pending.
import cpu_defs::*;

module exc_prio_enc (
    input  logic       int_happen,
    input  logic [5:0] wb_exc,
    input  logic       wb_eret,
    output logic [6:0] exc_type,
    output logic       is_eret
);

    logic [7:0] req;
    logic [7:0] grant;
    logic [7:0] taken;

    // Requests laid out in priority order, slot 0 highest
    assign req = {wb_eret,
                  wb_exc[WB_ADES],
                  wb_exc[WB_BP],
                  wb_exc[WB_SYS],
                  wb_exc[WB_OV],
                  wb_exc[WB_RI],
                  wb_exc[WB_ADEL],
                  int_happen};

    assign taken[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chain
            assign grant[gi] = req[gi] & ~taken[gi];
            if (gi < 7) begin : g_carry
                assign taken[gi+1] = taken[gi] | req[gi];
            end
        end
    endgenerate

    // Back to CP0 ordering {int, adel, ades, sys, bp, ri, ov}
    assign exc_type = {grant[0], grant[1], grant[6], grant[4],
                       grant[5], grant[2], grant[3]};
    assign is_eret  = grant[7];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between commit and CP0: accepts one event,
// flushes for FLUSH_CYCLES, then hands a redirect to fetch.
import cpu_defs::*;

module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [5:0]  wb_exc,
    input  logic        wb_eret,
    input  logic [31:0] wb_pc,
    input  logic        wb_is_slot,
    input  logic [31:0] wb_badvaddr,
    input  logic        int_happen,
    input  logic [31:0] cp0_epc,
    output logic [6:0]  exc_type,
    output logic [31:0] exc_pc,
    output logic        exc_is_slot,
    output logic [31:0] exc_badvaddr,
    output logic        eret_out,
    output logic        flush,
    output logic        wb_stall,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam bit         FLUSH_OK   = (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 15);

    exc_state_t  state_reg;
    logic [3:0]  cnt_reg;
    logic [6:0]  exc_type_reg;
    logic [31:0] exc_pc_reg;
    logic        exc_is_slot_reg;
    logic [31:0] exc_badvaddr_reg;
    logic        eret_reg;
    logic        flush_reg;
    logic        stall_reg;
    logic        redir_valid_reg;
    logic [31:0] redir_pc_reg;

    logic [6:0]  enc_type;
    logic        enc_eret;
    logic        accept;

    exc_prio_enc u_prio (
        .int_happen (int_happen),
        .wb_exc     (wb_exc),
        .wb_eret    (wb_eret),
        .exc_type   (enc_type),
        .is_eret    (enc_eret)
    );

    // Interrupts are only taken alongside a valid commit
    assign accept = (state_reg == ST_IDLE) && wb_valid &&
                    (int_happen || (|wb_exc) || wb_eret);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            exc_type_reg     <= '0;
            exc_pc_reg       <= '0;
            exc_is_slot_reg  <= 1'b0;
            exc_badvaddr_reg <= '0;
            eret_reg         <= 1'b0;
            flush_reg        <= 1'b0;
            stall_reg        <= 1'b0;
            redir_valid_reg  <= 1'b0;
            redir_pc_reg     <= '0;
        end else begin
            exc_type_reg <= '0;
            eret_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        exc_type_reg     <= enc_type;
                        eret_reg         <= enc_eret;
                        exc_pc_reg       <= wb_pc;
                        exc_is_slot_reg  <= wb_is_slot;
                        exc_badvaddr_reg <= wb_badvaddr;
                        redir_pc_reg     <= enc_eret ? cp0_epc : EXC_VECTOR;
                        cnt_reg          <= FLUSH_LOAD;
                        flush_reg        <= 1'b1;
                        stall_reg        <= 1'b1;
                        state_reg        <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_reg == 4'd1) begin
                        flush_reg       <= 1'b0;
                        redir_valid_reg <= 1'b1;
                        state_reg       <= ST_REDIR;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_REDIR: begin
                    if (redir_ready) begin
                        redir_valid_reg <= 1'b0;
                        stall_reg       <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: begin
                    flush_reg       <= 1'b0;
                    stall_reg       <= 1'b0;
                    redir_valid_reg <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
            endcase
        end
    end

    a_flush_range: assert property (@(posedge clk) FLUSH_OK);

    assign exc_type     = exc_type_reg;
    assign exc_pc       = exc_pc_reg;
    assign exc_is_slot  = exc_is_slot_reg;
    assign exc_badvaddr = exc_badvaddr_reg;
    assign eret_out     = eret_reg;
    assign flush        = flush_reg;
    assign wb_stall     = stall_reg;
    assign redir_valid  = redir_valid_reg;
    assign redir_pc     = redir_pc_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: priority, flush timing, redirect handshake,
// back-pressure, mid-flush reset and ignored invalid commits.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic [5:0]  wb_exc;
    logic        wb_eret;
    logic [31:0] wb_pc;
    logic        wb_is_slot;
    logic [31:0] wb_badvaddr;
    logic        int_happen;
    logic [31:0] cp0_epc;
    logic [6:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_is_slot;
    logic [31:0] exc_badvaddr;
    logic        eret_out;
    logic        flush;
    logic        wb_stall;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_valid     (wb_valid),
        .wb_exc       (wb_exc),
        .wb_eret      (wb_eret),
        .wb_pc        (wb_pc),
        .wb_is_slot   (wb_is_slot),
        .wb_badvaddr  (wb_badvaddr),
        .int_happen   (int_happen),
        .cp0_epc      (cp0_epc),
        .exc_type     (exc_type),
        .exc_pc       (exc_pc),
        .exc_is_slot  (exc_is_slot),
        .exc_badvaddr (exc_badvaddr),
        .eret_out     (eret_out),
        .flush        (flush),
        .wb_stall     (wb_stall),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_wb();
        wb_valid    = 1'b0;
        wb_exc      = '0;
        wb_eret     = 1'b0;
        int_happen  = 1'b0;
        wb_is_slot  = 1'b0;
        wb_pc       = '0;
        wb_badvaddr = '0;
    endtask

    // Presents one event at a negedge (DUT idle) and walks it through to IDLE
    task automatic run_event(input string tag, input logic [5:0] exc, input logic intr,
                             input logic eret, input logic [31:0] pc, input logic [31:0] bad,
                             input logic [6:0] exp_type, input logic exp_eret,
                             input logic [31:0] exp_redir);
        wb_valid = 1'b1; wb_exc = exc; int_happen = intr; wb_eret = eret;
        wb_pc = pc; wb_badvaddr = bad; wb_is_slot = pc[2];
        @(negedge clk);
        chk({tag, ".type"}, {25'd0, exc_type}, {25'd0, exp_type});
        chk({tag, ".eret"}, {31'd0, eret_out}, {31'd0, exp_eret});
        chk({tag, ".pc"}, exc_pc, pc);
        chk({tag, ".slot"}, {31'd0, exc_is_slot}, {31'd0, pc[2]});
        chk({tag, ".bad"}, exc_badvaddr, bad);
        chk({tag, ".flush1"}, {31'd0, flush}, 32'd1);
        chk({tag, ".stall1"}, {31'd0, wb_stall}, 32'd1);
        clear_wb();
        @(negedge clk);
        chk({tag, ".pulse"}, {24'd0, eret_out, exc_type}, 32'd0);
        chk({tag, ".flush2"}, {31'd0, flush}, 32'd1);
        chk({tag, ".rv_early"}, {31'd0, redir_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".flush3"}, {31'd0, flush}, 32'd0);
        chk({tag, ".rv"}, {31'd0, redir_valid}, 32'd1);
        chk({tag, ".rpc"}, redir_pc, exp_redir);
        chk({tag, ".stall3"}, {31'd0, wb_stall}, 32'd1);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk({tag, ".rv_done"}, {31'd0, redir_valid}, 32'd0);
        chk({tag, ".stall_done"}, {31'd0, wb_stall}, 32'd0);
        $display("event %s: type=%b eret=%b redir=%h", tag, exp_type, exp_eret, exp_redir);
    endtask

    initial begin
        resetn = 1'b0;
        redir_ready = 1'b0;
        cp0_epc = '0;
        clear_wb();
        repeat (2) @(negedge clk);
        chk("rst.type", {25'd0, exc_type}, 32'd0);
        chk("rst.ctrl", {28'd0, eret_out, flush, wb_stall, redir_valid}, 32'd0);
        chk("rst.rpc", redir_pc, 32'd0);
        chk("rst.epc", exc_pc, 32'd0);
        chk("rst.bad", exc_badvaddr, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Invalid commit with pending interrupt and ov: nothing happens
        wb_valid = 1'b0; int_happen = 1'b1; wb_exc = 6'b000001; wb_pc = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            chk("novalid.type", {25'd0, exc_type}, 32'd0);
            chk("novalid.ctrl", {29'd0, flush, wb_stall, redir_valid}, 32'd0);
            chk("novalid.pc", exc_pc, 32'd0);
        end
        clear_wb();

        run_event("ri", 6'b000010, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 7'b0000010, 1'b0, VEC);
        run_event("int", 6'b100001, 1'b1, 1'b1, 32'h8000_0024, 32'h1, 7'b1000000, 1'b0, VEC);
        run_event("adel_ri", 6'b100010, 1'b0, 1'b0, 32'h8000_0030, 32'hDEAD_BEE1, 7'b0100000, 1'b0, VEC);
        run_event("ri_ov", 6'b000011, 1'b0, 1'b0, 32'h8000_0034, 32'h0, 7'b0000010, 1'b0, VEC);
        run_event("ov_sys", 6'b001001, 1'b0, 1'b0, 32'h8000_0038, 32'h0, 7'b0000001, 1'b0, VEC);
        run_event("sys_bp", 6'b001100, 1'b0, 1'b0, 32'h8000_003C, 32'h0, 7'b0001000, 1'b0, VEC);
        run_event("bp_ades", 6'b010100, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 7'b0000100, 1'b0, VEC);
        run_event("ades_eret", 6'b010000, 1'b0, 1'b1, 32'h8000_0044, 32'h0000_0FF2, 7'b0010000, 1'b0, VEC);

        // eret, then hold redirect back-pressure while a sys is presented
        cp0_epc = 32'h8000_0100;
        wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'h8000_0200;
        @(negedge clk);
        chk("eret.pulse", {31'd0, eret_out}, 32'd1);
        chk("eret.type", {25'd0, exc_type}, 32'd0);
        clear_wb();
        @(negedge clk);
        chk("eret.pulse_end", {31'd0, eret_out}, 32'd0);
        @(negedge clk);
        chk("eret.rv", {31'd0, redir_valid}, 32'd1);
        chk("eret.rpc", redir_pc, 32'h8000_0100);
        cp0_epc = 32'h1111_2222;
        wb_valid = 1'b1; wb_exc = 6'b001000; wb_pc = 32'h8000_0300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.rv", {31'd0, redir_valid}, 32'd1);
            chk("hold.rpc", redir_pc, 32'h8000_0100);
            chk("hold.stall", {31'd0, wb_stall}, 32'd1);
            chk("hold.type", {25'd0, exc_type}, 32'd0);
        end
        $display("eret: redirect held 5 cycles at %h", redir_pc);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("hs.rv", {31'd0, redir_valid}, 32'd0);
        chk("hs.stall", {31'd0, wb_stall}, 32'd0);
        chk("hs.type", {25'd0, exc_type}, 32'd0);
        @(negedge clk);
        chk("sys.type", {25'd0, exc_type}, 32'h0000_0008);
        chk("sys.pc", exc_pc, 32'h8000_0300);
        clear_wb();
        repeat (2) @(negedge clk);
        chk("sys.rpc", redir_pc, VEC);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        $display("sys: accepted after handshake");

        // Reset while the flush counter sits at 1
        wb_valid = 1'b1; wb_exc = 6'b000001; wb_pc = 32'h8000_0400;
        @(negedge clk);
        clear_wb();
        @(negedge clk);
        chk("mid.flush", {31'd0, flush}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid.ctrl", {28'd0, eret_out, flush, wb_stall, redir_valid}, 32'd0);
        chk("mid.type", {25'd0, exc_type}, 32'd0);
        chk("mid.rpc", redir_pc, 32'd0);
        chk("mid.pc", exc_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post.rv", {31'd0, redir_valid}, 32'd0);
            chk("post.flush", {30'd0, flush, wb_stall}, 32'd0);
        end
        $display("reset: mid-flush reset cleared state");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
